// File: rtl/digit_scan_ctrl_if.sv
// Scan-request / decoder-drive bundle between a scan master and digit_scan_ctrl.
// The master drives run and digit_mask; the controller returns sel, en and slot_start.
interface digit_scan_ctrl_if;
    logic       run;
    logic [3:0] digit_mask;
    logic [1:0] sel;
    logic       en;
    logic       slot_start;

    modport master (
        output run,
        output digit_mask,
        input  sel,
        input  en,
        input  slot_start
    );

    modport slave (
        input  run,
        input  digit_mask,
        output sel,
        output en,
        output slot_start
    );
endinterface

// File: rtl/digit_scan_ctrl.sv
// Time-multiplexed scan sequencer driving a 2-to-4 decoder (sel/en), one blanked slot per channel.
// Define DIGIT_SCAN_SKIP_EN to skip channels whose mask bit is clear instead of giving them a dark slot.
module digit_scan_ctrl #(
    parameter int TICK_DIV  = 1000,
    parameter int BLANK_CYC = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    digit_scan_ctrl_if.slave   bus
);

    localparam int             CW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]  CNT_LAST   = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0]  CNT_BLANK  = CW'(BLANK_CYC);
    localparam bit             BLANK_NONE = (BLANK_CYC == 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      sel_q, sel_d;
    logic [3:0]      mask_q, mask_d;
    logic            en_q, en_d;
    logic            slot_start_q, slot_start_d;
    logic            resume_q, resume_d;
    logic            begin_slot;
    logic [3:0]      search_m;

    // Cyclic search for the next allowed channel, starting at cur+1 and ending at cur itself.
    function automatic logic [1:0] next_chan(input logic [1:0] cur, input logic [3:0] m);
        logic [1:0] idx;
        logic [1:0] nxt;
        nxt = cur;
        for (int i = 4; i >= 1; i--) begin
            idx = cur + 2'(i);
            if (m[idx]) begin
                nxt = idx;
            end else begin
                nxt = nxt;
            end
        end
        return nxt;
    endfunction

`ifdef DIGIT_SCAN_SKIP_EN
    assign search_m = bus.digit_mask;
`else
    assign search_m = 4'b1111;
`endif

    // Next-state, counter, channel selection and registered-output precomputation.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sel_d        = sel_q;
        mask_d       = mask_q;
        resume_d     = resume_q;
        en_d         = 1'b0;
        slot_start_d = 1'b0;
        begin_slot   = 1'b0;

        if (!bus.run) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            // An interrupted scan restarts at the channel after the one that was cut off.
            if (state_q != ST_IDLE) begin
                resume_d = 1'b1;
            end else begin
                resume_d = resume_q;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.digit_mask != 4'b0000) begin
                        mask_d     = bus.digit_mask;
                        sel_d      = next_chan(resume_q ? sel_q : 2'd3, search_m);
                        begin_slot = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_BLANK, ST_DRIVE: begin
                    if (cnt_q == CNT_LAST) begin
                        mask_d = bus.digit_mask;
                        if (bus.digit_mask == 4'b0000) begin
                            state_d  = ST_IDLE;
                            cnt_d    = '0;
                            resume_d = 1'b0;
                        end else begin
                            sel_d      = next_chan(sel_q, search_m);
                            begin_slot = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_d == CNT_BLANK) begin
                            state_d = ST_DRIVE;
                        end else begin
                            state_d = state_q;
                        end
                        en_d = (state_d == ST_DRIVE) && mask_q[sel_q];
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        if (begin_slot) begin
            cnt_d        = '0;
            slot_start_d = 1'b1;
            resume_d     = 1'b0;
            state_d      = BLANK_NONE ? ST_DRIVE : ST_BLANK;
            en_d         = BLANK_NONE && mask_d[sel_d];
        end else begin
            slot_start_d = 1'b0;
        end
    end

    // State and output registers; reset clears everything asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            sel_q        <= 2'd0;
            mask_q       <= 4'b0000;
            en_q         <= 1'b0;
            slot_start_q <= 1'b0;
            resume_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sel_q        <= sel_d;
            mask_q       <= mask_d;
            en_q         <= en_d;
            slot_start_q <= slot_start_d;
            resume_q     <= resume_d;
        end
    end

    assign bus.sel        = sel_q;
    assign bus.en         = en_q;
    assign bus.slot_start = slot_start_q;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Scoreboard bench for digit_scan_ctrl: dut0 uses TICK_DIV=8/BLANK_CYC=2, dut1 uses TICK_DIV=8/BLANK_CYC=0.
module tb_digit_scan_ctrl;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    // Each entry is {sel[1:0], en, slot_start}.
    logic [3:0] sb[$];

    digit_scan_ctrl_if bus0();
    digit_scan_ctrl_if bus1();

    digit_scan_ctrl #(.TICK_DIV(8), .BLANK_CYC(2)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    digit_scan_ctrl #(.TICK_DIV(8), .BLANK_CYC(0)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus0.run = 1'b0;
        bus0.digit_mask = 4'b0000;
        bus1.run = 1'b0;
        bus1.digit_mask = 4'b0000;
        sb.delete();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [3:0] got;
        rst_n = 1'b0;
        bus0.run = 1'b0;
        bus0.digit_mask = 4'b0000;
        bus1.run = 1'b0;
        bus1.digit_mask = 4'b0000;
        #1;
        for (int i = 0; i < 3; i++) begin
            sb.push_back(4'b0000);
            got = {bus0.sel, bus0.en, bus0.slot_start};
            checks++;
            if (got !== sb.pop_front()) begin
                errors++;
                $display("FAIL reset step%0d got sel/en/ss=%b expected 0000", i, got);
            end
            tick();
        end
        rst_n = 1'b1;
    endtask

    task automatic test_full_mask();
        logic [3:0] exp, got;
        logic [1:0] sv;
        do_reset();
        bus0.run = 1'b1;
        bus0.digit_mask = 4'b1111;
        for (int s = 0; s < 5; s++) begin
            for (int c = 0; c < 8; c++) begin
                sv = 2'(s % 4);
                sb.push_back({sv, c >= 2, c == 0});
                tick();
                exp = sb.pop_front();
                got = {bus0.sel, bus0.en, bus0.slot_start};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL full_mask slot%0d cyc%0d got sel/en/ss=%b expected %b", s, c, got, exp);
                end
            end
        end
        bus0.run = 1'b0;
    endtask

    task automatic test_reset_mid_slot();
        logic [3:0] exp, got;
        logic [1:0] sv;
        do_reset();
        bus0.run = 1'b1;
        bus0.digit_mask = 4'b1111;
        for (int n = 0; n < 21; n++) begin
            sv = 2'(n / 8);
            sb.push_back({sv, (n % 8) >= 2, (n % 8) == 0});
            tick();
            exp = sb.pop_front();
            got = {bus0.sel, bus0.en, bus0.slot_start};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL rst_mid_pre n%0d got sel/en/ss=%b expected %b", n, got, exp);
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            sb.push_back(4'b0000);
            got = {bus0.sel, bus0.en, bus0.slot_start};
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL rst_mid_hold step%0d got sel/en/ss=%b expected %b", i, got, exp);
            end
            tick();
        end
        bus0.run = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_sparse_mask();
        logic [3:0] exp, got;
        logic [1:0] sv;
        logic       ev;
        do_reset();
        bus0.run = 1'b1;
        bus0.digit_mask = 4'b0101;
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 8; c++) begin
`ifdef DIGIT_SCAN_SKIP_EN
                sv = 2'((s % 2) * 2);
                ev = (c >= 2);
`else
                sv = 2'(s % 4);
                ev = (c >= 2) && ((s % 2) == 0);
`endif
                sb.push_back({sv, ev, c == 0});
                tick();
                exp = sb.pop_front();
                got = {bus0.sel, bus0.en, bus0.slot_start};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL sparse slot%0d cyc%0d got sel/en/ss=%b expected %b", s, c, got, exp);
                end
            end
        end
        bus0.run = 1'b0;
    endtask

    task automatic test_run_drop();
        logic [3:0] exp, got;
        logic [1:0] sv;
        do_reset();
        bus0.run = 1'b1;
        bus0.digit_mask = 4'b1111;
        for (int n = 0; n < 13; n++) begin
            sv = 2'(n / 8);
            sb.push_back({sv, (n % 8) >= 2, (n % 8) == 0});
            tick();
            exp = sb.pop_front();
            got = {bus0.sel, bus0.en, bus0.slot_start};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL run_drop_pre n%0d got sel/en/ss=%b expected %b", n, got, exp);
            end
        end
        bus0.run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sb.push_back({2'd1, 1'b0, 1'b0});
            tick();
            exp = sb.pop_front();
            got = {bus0.sel, bus0.en, bus0.slot_start};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL run_drop_idle i%0d got sel/en/ss=%b expected %b", i, got, exp);
            end
        end
        bus0.run = 1'b1;
        for (int n = 0; n < 9; n++) begin
            sv = (n < 8) ? 2'd2 : 2'd3;
            sb.push_back({sv, (n % 8) >= 2, (n % 8) == 0});
            tick();
            exp = sb.pop_front();
            got = {bus0.sel, bus0.en, bus0.slot_start};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL run_drop_resume n%0d got sel/en/ss=%b expected %b", n, got, exp);
            end
        end
        bus0.run = 1'b0;
    endtask

    task automatic test_mask_edges();
        logic [3:0] exp, got;
        do_reset();
        bus0.run = 1'b1;
        bus0.digit_mask = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            sb.push_back(4'b0000);
            tick();
            exp = sb.pop_front();
            got = {bus0.sel, bus0.en, bus0.slot_start};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL mask_zero i%0d got sel/en/ss=%b expected %b", i, got, exp);
            end
        end
        bus0.digit_mask = 4'b1111;
        for (int c = 0; c < 12; c++) begin
            if (c == 4) begin
                bus0.digit_mask = 4'b0000;
            end
            sb.push_back({2'd0, (c >= 2) && (c < 8), c == 0});
            tick();
            exp = sb.pop_front();
            got = {bus0.sel, bus0.en, bus0.slot_start};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL mask_drop cyc%0d got sel/en/ss=%b expected %b", c, got, exp);
            end
        end
        bus0.run = 1'b0;
    endtask

    task automatic test_blank_zero();
        logic [3:0] exp, got;
        logic [1:0] sv;
        do_reset();
        bus1.run = 1'b1;
        bus1.digit_mask = 4'b1111;
        for (int s = 0; s < 5; s++) begin
            for (int c = 0; c < 8; c++) begin
                sv = 2'(s % 4);
                sb.push_back({sv, 1'b1, c == 0});
                tick();
                exp = sb.pop_front();
                got = {bus1.sel, bus1.en, bus1.slot_start};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL blank0 slot%0d cyc%0d got sel/en/ss=%b expected %b", s, c, got, exp);
                end
            end
        end
        bus1.run = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_full_mask();
        test_reset_mid_slot();
        test_sparse_mask();
        test_run_drop();
        test_mask_edges();
        test_blank_zero();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/digit_scan_ctrl.md
# digit_scan_ctrl

Time-multiplexed scan sequencer that drives the 2-bit select and the active-high enable of the 2-to-4 enabled decoder stage, so one decoder output at a time is active. Each of four channels (e.g. display digits) gets a fixed-length slot. Each slot starts with an anti-ghosting blanking window, and per-channel mask bits control which channels are lit. Sits directly upstream of the decoder: `sel` feeds the decoder address and `en` feeds the decoder enable.

## Interface
- `TICK_DIV`, 1000 — clock cycles per channel slot; legal range `TICK_DIV > BLANK_CYC`, `TICK_DIV >= 2`.
- `BLANK_CYC`, 4 — cycles at the start of each slot with `en` forced low; 0 is legal.
- `clk` input 1 — single clock; all state updates on the rising edge.
- `rst_n` input 1 — reset, asynchronous and active-low.
- `run` input 1 — scan request; level-sensitive.
- `digit_mask` input 4 — per-channel light enable; bit i refers to channel i.
- `sel` output 2 — channel index to the decoder address.
- `en` output 1 — decoder enable.
- `slot_start` output 1 — one-cycle pulse on the first cycle of every slot.

## Operation
- All outputs are registered.
- Reset values: `sel`=0, `en`=0, `slot_start`=0, state IDLE, slot counter 0, `mask_q`=0.
- States:
  - IDLE: `en`=0; `sel` holds its value.
  - BLANK: `en`=0 for `BLANK_CYC` cycles.
  - DRIVE: `en`=`mask_q[sel]` for `TICK_DIV-BLANK_CYC` cycles.
- IDLE→slot: occurs when `run`=1 and `digit_mask`≠0.
  - First channel is index 0, or the lowest set mask bit in the skip build.
  - `digit_mask` is captured into `mask_q`.
  - The new slot begins in BLANK, or in DRIVE if `BLANK_CYC`=0.
- Slot counter counts 0..`TICK_DIV-1`; BLANK→DRIVE when the counter reaches `BLANK_CYC`.
- At the end of the slot (counter = `TICK_DIV-1`), with `run` still 1:
  - Sample `digit_mask` into `mask_q`.
  - Advance `sel` to the next channel, modulo 4, wrapping 3→0.
  - Begin the next slot with `slot_start`=1.
- `digit_mask` changes inside a slot have no effect until the next slot boundary.
- `digit_mask`=0 sampled at a slot boundary → IDLE, `en`=0, no `slot_start`.
- `run`=0 in any state → IDLE at the next edge. `en` is 0 from that edge, the counter clears and `sel` holds.
  - Re-asserting `run` starts a fresh full slot at the next channel. The interrupted channel is not resumed.
- `rst_n` asserted mid-slot → all outputs go to reset values immediately, without waiting for a clock edge.
- Slot counter width: `$clog2(TICK_DIV)`. The counter never exceeds `TICK_DIV-1`.

## Timing
- `run` sampled high at edge k (from IDLE) → at edge k+1, `sel` is valid and `slot_start`=1.
- `en` rises at edge k+1+`BLANK_CYC`.
- Slot period is exactly `TICK_DIV` cycles. `sel` changes only on the `slot_start` edge, and always while `en`=0 (unless `BLANK_CYC`=0).
- `en` high time per lit slot: `TICK_DIV-BLANK_CYC` cycles.
- With `BLANK_CYC`=0 and a full mask, `en` stays high continuously across slot boundaries.
- `run` low at edge m → `en`=0 and `slot_start`=0 at edge m+1.

## Configuration
- Macro `DIGIT_SCAN_SKIP_EN`.
- Defined: channels whose `mask_q` bit is 0 are skipped.
  - `sel` advances to the next set bit, searching cyclically from `sel+1`.
  - Every slot is a lit slot.
  - A single set bit means `sel` stays constant and `slot_start` still pulses every `TICK_DIV` cycles.
- Undefined: `sel` always steps 0,1,2,3,0…
  - Masked channels still get their slot, with `en`=0 for the whole slot.
  - This keeps a fixed frame of 4×`TICK_DIV` cycles.

## Test plan
Bench parameters: `TICK_DIV`=8, `BLANK_CYC`=2 unless noted.
- **Reset mid-slot:** assert `rst_n`=0 during DRIVE with `sel`=2 → `sel`=0, `en`=0, `slot_start`=0 immediately, without waiting for a clock edge; outputs stay there until release.
- **Full mask:** `run`=1, `digit_mask`=4'b1111 → `sel` sequence 0,1,2,3,0, each held 8 cycles. `slot_start` pulses every 8 cycles. `en` is high on cycles 2..7 of each slot.
- **Sparse mask 4'b0101:**
  - With `DIGIT_SCAN_SKIP_EN`: `sel` goes 0,2,0,2 with 8-cycle slots.
  - Without it: `sel` goes 0,1,2,3, with `en` high only in slots 0 and 2.
- **`run` drop:** drop `run` on cycle 4 of slot 1 → `en`=0 next edge and `sel` held at 1. Re-raising `run` → `slot_start` with `sel`=2, and `en` rises 2 cycles later.
- **Mask edge cases:** `digit_mask`=0 with `run`=1 → `en`, `slot_start` stay 0. Mask set to 0 mid-slot → the current slot completes unchanged, then the block enters IDLE.
- **`BLANK_CYC`=0:** full mask → `en` high on the `slot_start` cycle and continuously thereafter; `sel` steps every 8 cycles.
